rgb_gray_stream_ctrl: RTL and testbench

Stream-side controller that feeds 24-bit RGB pixels into the floating-point RGB-to-gray datapath and collects its 8-bit gray results. Upstream it offers a valid/ready pixel port; toward the datapath it drives the pixel bus and the output-register load strobe. Downstream it presents gray bytes on a valid/ready port through a small FIFO. Credit-based admission guarantees no result is ever dropped when the consumer stalls.

---
 rtl/rgb_gray_stream_ctrl.sv | 154 +++++++++++++++
 tb/tb_rgb_gray_stream_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_gray_stream_ctrl.sv
// rgb_gray_stream_ctrl: feeds RGB pixels into the gray datapath and buffers its results.
// Admission is credit based: every accepted pixel reserves one output FIFO slot, so a
// result that comes out of the datapath always has room, even while the consumer stalls.
module rgb_gray_stream_ctrl #(
    parameter int unsigned PIPE_LATENCY = 12,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic        CLK,
    input  logic        Clear,
    input  logic [23:0] Pix_In,
    input  logic        Pix_Last,
    input  logic        Pix_Valid,
    output logic        Pix_Ready,
    output logic [23:0] Dp_Data,
    output logic        Dp_Load,
    input  logic [7:0]  Dp_Gray,
    output logic [7:0]  Gray_Out,
    output logic        Gray_Last,
    output logic        Gray_Valid,
    input  logic        Gray_Ready,
    output logic        Frame_Done,
    output logic        Busy
);

    localparam int unsigned PIX_W  = 24;
    localparam int unsigned GRAY_W = 8;
    localparam int unsigned AW     = $clog2(FIFO_DEPTH);
    localparam int unsigned PW     = AW + 1;
    localparam int unsigned CW     = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic              last;
        logic [GRAY_W-1:0] gray;
    } gray_entry_t;

    logic [PIPE_LATENCY-1:0] tok_valid_q, tok_valid_d;
    logic [PIPE_LATENCY-1:0] tok_last_q,  tok_last_d;
    logic [PIX_W-1:0]        dp_data_q,   dp_data_d;
    logic                    cap_pend_q,  cap_pend_d;
    logic                    cap_last_q,  cap_last_d;
    logic [PW-1:0]           wr_ptr_q,    wr_ptr_d;
    logic [PW-1:0]           rd_ptr_q,    rd_ptr_d;
    logic [CW-1:0]           credits_q,   credits_d;
    logic                    frame_done_q, frame_done_d;
    gray_entry_t             mem_q [FIFO_DEPTH];
    gray_entry_t             mem_d [FIFO_DEPTH];

    logic        credit_ok_c;
    logic        accept_c;
    logic        pop_c;
    logic        fifo_empty_c;
    logic        fifo_full_c;
    logic        wr_en_c;
    gray_entry_t head_c;

    // Handshake qualifiers and FIFO status decoded from registered state.
    // Clear only gates the outward ready; the flops are already held by the async reset.
    always_comb begin
        credit_ok_c  = (credits_q < CW'(FIFO_DEPTH));
        accept_c     = Pix_Valid && credit_ok_c;
        fifo_empty_c = (wr_ptr_q == rd_ptr_q);
        fifo_full_c  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop_c        = !fifo_empty_c && Gray_Ready;
        wr_en_c      = cap_pend_q && (!fifo_full_c || pop_c);
        head_c       = mem_q[rd_ptr_q[AW-1:0]];
    end

    // Pixel register and token pipeline that tracks each pixel through the datapath.
    always_comb begin
        dp_data_d   = dp_data_q;
        tok_valid_d = {tok_valid_q[PIPE_LATENCY-2:0], accept_c};
        tok_last_d  = {tok_last_q[PIPE_LATENCY-2:0], accept_c && Pix_Last};
        if (accept_c) begin
            dp_data_d = Pix_In;
        end
    end

    // The datapath output register loads with Dp_Load; its result is captured one cycle later.
    always_comb begin
        cap_pend_d = tok_valid_q[PIPE_LATENCY-1];
        cap_last_d = tok_last_q[PIPE_LATENCY-1];
    end

    // Output FIFO write/read pointers and storage; a write is never visible in the same cycle.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (wr_en_c) begin
            mem_d[wr_ptr_q[AW-1:0]] = '{last: cap_last_q, gray: Dp_Gray};
            wr_ptr_d                = wr_ptr_q + PW'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    // Credits count pixels accepted but not yet popped (in flight + pending + buffered).
    always_comb begin
        credits_d = credits_q;
        unique case ({accept_c, pop_c})
            2'b10:   credits_d = credits_q + CW'(1);
            2'b01:   credits_d = credits_q - CW'(1);
            default: credits_d = credits_q;
        endcase
    end

    // End-of-frame pulse follows the pop of a last-tagged entry.
    always_comb begin
        frame_done_d = pop_c && head_c.last;
    end

    // State registers; Clear discards everything in flight and everything buffered.
    always_ff @(posedge CLK or posedge Clear) begin
        if (Clear) begin
            tok_valid_q  <= '0;
            tok_last_q   <= '0;
            dp_data_q    <= '0;
            cap_pend_q   <= 1'b0;
            cap_last_q   <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            credits_q    <= '0;
            frame_done_q <= 1'b0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            tok_valid_q  <= tok_valid_d;
            tok_last_q   <= tok_last_d;
            dp_data_q    <= dp_data_d;
            cap_pend_q   <= cap_pend_d;
            cap_last_q   <= cap_last_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            credits_q    <= credits_d;
            frame_done_q <= frame_done_d;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign Pix_Ready  = credit_ok_c && !Clear;
    assign Dp_Data    = dp_data_q;
    assign Dp_Load    = tok_valid_q[PIPE_LATENCY-1];
    assign Gray_Out   = head_c.gray;
    assign Gray_Last  = head_c.last;
    assign Gray_Valid = !fifo_empty_c;
    assign Frame_Done = frame_done_q;
    assign Busy       = (credits_q != '0);

endmodule

// File: tb/tb_rgb_gray_stream_ctrl.sv
// Bench for rgb_gray_stream_ctrl: datapath stub, credit/order scoreboard, directed phases.
module tb_rgb_gray_stream_ctrl;

    localparam int PL = 12;
    localparam int FD = 4;

    logic        CLK;
    logic        Clear;
    logic [23:0] Pix_In;
    logic        Pix_Last;
    logic        Pix_Valid;
    logic        Pix_Ready;
    logic [23:0] Dp_Data;
    logic        Dp_Load;
    logic [7:0]  Dp_Gray;
    logic [7:0]  Gray_Out;
    logic        Gray_Last;
    logic        Gray_Valid;
    logic        Gray_Ready;
    logic        Frame_Done;
    logic        Busy;

    rgb_gray_stream_ctrl #(.PIPE_LATENCY(PL), .FIFO_DEPTH(FD)) dut (
        .CLK(CLK), .Clear(Clear), .Pix_In(Pix_In), .Pix_Last(Pix_Last),
        .Pix_Valid(Pix_Valid), .Pix_Ready(Pix_Ready), .Dp_Data(Dp_Data),
        .Dp_Load(Dp_Load), .Dp_Gray(Dp_Gray), .Gray_Out(Gray_Out),
        .Gray_Last(Gray_Last), .Gray_Valid(Gray_Valid), .Gray_Ready(Gray_Ready),
        .Frame_Done(Frame_Done), .Busy(Busy)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Datapath stub: red channel delayed through the pipeline, held in an output register.
    logic [7:0] stub_pipe [PL-1];
    always @(posedge CLK) begin
        stub_pipe[0] <= Dp_Data[23:16];
        for (int i = 1; i < PL - 1; i++) stub_pipe[i] <= stub_pipe[i-1];
        if (Dp_Load) Dp_Gray <= stub_pipe[PL-2];
    end

    typedef struct packed {
        logic [7:0] gray;
        logic       last;
    } exp_t;

    typedef struct {
        logic        valid;
        logic        last;
        logic [23:0] pix;
        logic        rdy;
        logic        e_load;
        logic        e_gv;
        logic [7:0]  e_gout;
        logic        e_glast;
        logic        e_fd;
        logic        e_busy;
        logic [23:0] e_dp;
    } vec_t;

    exp_t exp_q[$];
    vec_t tv[16];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   fd_count = 0;
    int   lasts_acc = 0;
    int   lasts_pop = 0;
    logic last_acc = 1'b0;
    logic last_pop = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: model checks before the edge, scoreboard update, Frame_Done after the edge.
    task automatic step();
        logic acc;
        logic pp;
        logic fd_exp;
        exp_t e;
        #1;
        acc = Pix_Valid && Pix_Ready;
        pp  = Gray_Valid && Gray_Ready;
        chk("pix_ready_credit", 32'(Pix_Ready), 32'(exp_q.size() < FD));
        chk("busy_credit", 32'(Busy), 32'(exp_q.size() != 0));
        fd_exp = 1'b0;
        if (pp) begin
            chk("pop_model_nonempty", 32'(exp_q.size() != 0), 32'(1));
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("gray_out", 32'(Gray_Out), 32'(e.gray));
                chk("gray_last", 32'(Gray_Last), 32'(e.last));
                fd_exp = e.last;
                if (e.last) lasts_pop++;
            end
        end
        if (acc) begin
            e.gray = Pix_In[23:16];
            e.last = Pix_Last;
            exp_q.push_back(e);
            if (Pix_Last) lasts_acc++;
        end
        last_acc = acc;
        last_pop = pp;
        @(posedge CLK);
        #1;
        chk("frame_done", 32'(Frame_Done), 32'(fd_exp));
        if (Frame_Done) fd_count++;
    endtask

    task automatic drain();
        Pix_Valid  = 1'b0;
        Pix_Last   = 1'b0;
        Gray_Ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0) break;
            step();
        end
        chk("drain_empty", 32'(exp_q.size()), 0);
        step();
        chk("drain_busy", 32'(Busy), 0);
        chk("drain_gray_valid", 32'(Gray_Valid), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        int popped;
        int acc_w;
        int pop_w;
        int fd0;
        int la0;

        Clear = 1'b1; Pix_In = '0; Pix_Last = 1'b0; Pix_Valid = 1'b0; Gray_Ready = 1'b0;

        // Reset values while Clear is high.
        #3;
        chk("rst_pix_ready", 32'(Pix_Ready), 0);
        chk("rst_dp_data", 32'(Dp_Data), 0);
        chk("rst_dp_load", 32'(Dp_Load), 0);
        chk("rst_gray_out", 32'(Gray_Out), 0);
        chk("rst_gray_last", 32'(Gray_Last), 0);
        chk("rst_gray_valid", 32'(Gray_Valid), 0);
        chk("rst_frame_done", 32'(Frame_Done), 0);
        chk("rst_busy", 32'(Busy), 0);
        repeat (2) @(posedge CLK);
        #1;
        Clear = 1'b0;
        #1;
        chk("rst_release_ready", 32'(Pix_Ready), 1);
        repeat (2) step();

        // Single pixel, cycle by cycle.
        for (int k = 0; k < 16; k++) begin
            tv[k].valid = 1'b0; tv[k].last = 1'b0; tv[k].pix = 24'h000000;
            tv[k].rdy = (k >= 14); tv[k].e_load = (k == 11); tv[k].e_gv = (k == 13);
            tv[k].e_gout = 8'hA5; tv[k].e_glast = 1'b1; tv[k].e_fd = (k == 14);
            tv[k].e_busy = (k < 14); tv[k].e_dp = 24'hA51234;
        end
        tv[0].valid = 1'b1; tv[0].last = 1'b1; tv[0].pix = 24'hA51234;
        for (int k = 0; k < 16; k++) begin
            Pix_Valid = tv[k].valid; Pix_Last = tv[k].last; Pix_In = tv[k].pix;
            Gray_Ready = tv[k].rdy;
            step();
            chk($sformatf("single_dp_load[%0d]", k), 32'(Dp_Load), 32'(tv[k].e_load));
            chk($sformatf("single_gray_valid[%0d]", k), 32'(Gray_Valid), 32'(tv[k].e_gv));
            if (tv[k].e_gv) begin
                chk($sformatf("single_gray_out[%0d]", k), 32'(Gray_Out), 32'(tv[k].e_gout));
                chk($sformatf("single_gray_last[%0d]", k), 32'(Gray_Last), 32'(tv[k].e_glast));
            end
            chk($sformatf("single_frame_done[%0d]", k), 32'(Frame_Done), 32'(tv[k].e_fd));
            chk($sformatf("single_busy[%0d]", k), 32'(Busy), 32'(tv[k].e_busy));
            chk($sformatf("single_dp_data[%0d]", k), 32'(Dp_Data), 32'(tv[k].e_dp));
        end

        // Streaming 64 pixels with the consumer always ready.
        sent = 0; popped = 0;
        Gray_Ready = 1'b1;
        for (int c = 0; c < 2000 && popped < 64; c++) begin
            Pix_Valid = (sent < 64);
            Pix_In    = {8'(sent), 8'h5A, 8'hC3};
            Pix_Last  = (sent == 63);
            step();
            if (last_acc) sent++;
            if (last_pop) popped++;
        end
        chk("stream_sent", 32'(sent), 64);
        chk("stream_popped", 32'(popped), 64);
        drain();

        // Backpressure: 10 pixels offered with the consumer stalled.
        sent = 0; popped = 0;
        Gray_Ready = 1'b0;
        for (int c = 0; c < 30; c++) begin
            Pix_Valid = 1'b1;
            Pix_In    = {8'(8'h80 + sent), 8'h11, 8'h22};
            Pix_Last  = (sent == 9);
            step();
            if (last_acc) sent++;
        end
        chk("bp_accepted", 32'(sent), 32'(FD));
        chk("bp_ready_low", 32'(Pix_Ready), 0);
        Gray_Ready = 1'b1;
        for (int c = 0; c < 300 && popped < 10; c++) begin
            Pix_Valid = (sent < 10);
            Pix_In    = {8'(8'h80 + sent), 8'h11, 8'h22};
            Pix_Last  = (sent == 9);
            step();
            if (last_acc) sent++;
            if (last_pop) popped++;
        end
        chk("bp_sent", 32'(sent), 10);
        chk("bp_delivered", 32'(popped), 10);
        drain();

        // Credits held at the limit while the consumer toggles.
        Gray_Ready = 1'b0;
        Pix_Valid  = 1'b1;
        Pix_Last   = 1'b0;
        for (int i = 0; i < FD; i++) begin
            Pix_In = {8'(8'hC0 + i), 8'h00, 8'h00};
            step();
        end
        Pix_Valid = 1'b0;
        repeat (16) step();
        chk("full_ready_low", 32'(Pix_Ready), 0);
        chk("full_gray_valid", 32'(Gray_Valid), 1);
        acc_w = 0; pop_w = 0;
        for (int c = 0; c < 40; c++) begin
            Gray_Ready = c[0];
            Pix_Valid  = 1'b1;
            Pix_In     = {8'(8'hD0 + c), 8'h00, 8'h00};
            step();
            if (last_acc) acc_w++;
            if (last_pop) pop_w++;
            chk("full_bound", 32'(exp_q.size() <= FD), 1);
        end
        chk("full_activity", 32'(acc_w > 0 && pop_w > 0), 1);
        drain();

        // Clear with two results buffered and two in flight.
        Gray_Ready = 1'b0;
        Pix_Valid  = 1'b1;
        Pix_Last   = 1'b1;
        for (int i = 0; i < 2; i++) begin
            Pix_In = {8'(8'hE0 + i), 8'h00, 8'h00};
            step();
        end
        Pix_Valid = 1'b0;
        repeat (16) step();
        Pix_Valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            Pix_In = {8'(8'hF0 + i), 8'h00, 8'h00};
            step();
        end
        Pix_Valid = 1'b0;
        repeat (3) step();
        chk("pre_clear_gray_valid", 32'(Gray_Valid), 1);
        Clear = 1'b1;
        #1;
        chk("clear_gray_valid", 32'(Gray_Valid), 0);
        chk("clear_pix_ready", 32'(Pix_Ready), 0);
        chk("clear_busy", 32'(Busy), 0);
        chk("clear_dp_load", 32'(Dp_Load), 0);
        exp_q.delete();
        @(posedge CLK);
        #1;
        Clear = 1'b0;
        #1;
        chk("clear_release_ready", 32'(Pix_Ready), 1);
        Gray_Ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step();
            chk("clear_no_output", 32'(Gray_Valid), 0);
            chk("clear_no_load", 32'(Dp_Load), 0);
        end

        // Random consumer over many pointer wraps.
        fd0 = fd_count; la0 = lasts_acc; sent = 0;
        for (int c = 0; c < 20000 && sent < 1000; c++) begin
            Pix_Valid  = ($urandom_range(0, 3) != 0) && (sent < 1000);
            Pix_In     = 24'($urandom);
            Pix_Last   = ($urandom_range(0, 7) == 0);
            Gray_Ready = 1'($urandom_range(0, 1));
            step();
            if (last_acc) sent++;
        end
        chk("wrap_sent", 32'(sent), 1000);
        drain();
        chk("wrap_frame_done_count", 32'(fd_count - fd0), 32'(lasts_acc - la0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
